// File: rtl/canny_pkg.sv
// Shared types and widths for the Canny front-end scan logic.
package canny_pkg;

    localparam int COORD_W = 10;
    localparam int ADDR_W  = 20;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN_R = 2'd1,
        ST_RUN_L = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

endpackage

// File: rtl/updown_counter.sv
// Saturating up/down counter with synchronous clear; clear beats inc/dec,
// and simultaneous inc and dec cancel out.
module updown_counter #(
    parameter int W   = 10,
    parameter int MAX = 1023
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAX_C  = W'(MAX);
    localparam logic [W-1:0] ONE_C  = W'(1);
    localparam logic [W-1:0] ZERO_C = W'(0);

    logic [W-1:0] count_r;

    // count register: saturates at 0 and MAX instead of wrapping
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_r <= ZERO_C;
        end else if (clr) begin
            count_r <= ZERO_C;
        end else if (inc && !dec && (count_r < MAX_C)) begin
            count_r <= count_r + ONE_C;
        end else if (dec && !inc && (count_r != ZERO_C)) begin
            count_r <= count_r - ONE_C;
        end else begin
            count_r <= count_r;
        end
    end

    assign q = count_r;

endmodule

// File: rtl/scan_controller.sv
// Serpentine window scanner: walks a WIN x WIN window over the image and
// tracks its pixel address. Define SCAN_ERR_CHECK_EN to add the sticky scan_err output.
module scan_controller
    import canny_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int WIN   = 9
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic               abort,
    input  logic               step_x,
    input  logic               step_y,
    output logic [COORD_W-1:0] readx,
    output logic [COORD_W-1:0] ready,
    output logic [ADDR_W-1:0]  addr,
    output logic               readx_up_max,
    output logic               readx_down_min,
    output logic               ready_max,
    output logic               busy,
    output logic               frame_done
`ifdef SCAN_ERR_CHECK_EN
,   output logic               scan_err
`endif
);

    localparam int                 X_MAX   = IMG_W - WIN;
    localparam int                 Y_MAX   = IMG_H - WIN;
    localparam logic [COORD_W-1:0] X_MAX_C = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] Y_MAX_C = COORD_W'(Y_MAX);
    localparam logic [COORD_W-1:0] ZERO_C  = COORD_W'(0);
    localparam logic [ADDR_W-1:0]  ROW_C   = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0]  ONE_A   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0]  ZERO_A  = ADDR_W'(0);

    scan_state_t         state_r;
    scan_state_t         state_nxt_s;
    logic                clr_s;
    logic                x_inc_s;
    logic                x_dec_s;
    logic                y_inc_s;
    logic                x_max_s;
    logic                x_min_s;
    logic                y_max_s;
    logic [ADDR_W-1:0]   addr_r;

    assign x_max_s = (readx == X_MAX_C);
    assign x_min_s = (readx == ZERO_C);
    assign y_max_s = (ready == Y_MAX_C);

    // state register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // next-state decode; abort overrides every state
    always_comb begin
        state_nxt_s = state_r;
        if (abort) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:  state_nxt_s = start ? ST_RUN_R : ST_IDLE;
                ST_RUN_R: state_nxt_s = step_y ? (y_max_s ? ST_DONE : ST_RUN_L) : ST_RUN_R;
                ST_RUN_L: state_nxt_s = step_y ? (y_max_s ? ST_DONE : ST_RUN_R) : ST_RUN_L;
                ST_DONE:  state_nxt_s = ST_IDLE;
                default:  state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // datapath strobes; step_y always wins over a same-cycle step_x
    always_comb begin
        clr_s   = 1'b0;
        x_inc_s = 1'b0;
        x_dec_s = 1'b0;
        y_inc_s = 1'b0;
        if (abort) begin
            clr_s = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    clr_s = start;
                end
                ST_RUN_R: begin
                    y_inc_s = step_y && !y_max_s;
                    x_inc_s = step_x && !step_y && !x_max_s;
                end
                ST_RUN_L: begin
                    y_inc_s = step_y && !y_max_s;
                    x_dec_s = step_x && !step_y && !x_min_s;
                end
                ST_DONE: begin
                    clr_s = 1'b0;
                end
                default: begin
                    clr_s = 1'b0;
                end
            endcase
        end
    end

    updown_counter #(.W(COORD_W), .MAX(X_MAX)) u_x_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .inc   (x_inc_s),
        .dec   (x_dec_s),
        .clr   (clr_s),
        .q     (readx)
    );

    updown_counter #(.W(COORD_W), .MAX(Y_MAX)) u_y_cnt (
        .clk   (clk),
        .n_rst (n_rst),
        .inc   (y_inc_s),
        .dec   (1'b0),
        .clr   (clr_s),
        .q     (ready)
    );

    // address tracks the counters step for step, so no multiplier is needed
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            addr_r <= ZERO_A;
        end else if (clr_s) begin
            addr_r <= ZERO_A;
        end else if (y_inc_s) begin
            addr_r <= addr_r + ROW_C;
        end else if (x_inc_s) begin
            addr_r <= addr_r + ONE_A;
        end else if (x_dec_s) begin
            addr_r <= addr_r - ONE_A;
        end else begin
            addr_r <= addr_r;
        end
    end

    assign addr           = addr_r;
    assign readx_up_max   = x_max_s;
    assign readx_down_min = x_min_s;
    assign ready_max      = y_max_s;
    assign busy           = (state_r != ST_IDLE);
    assign frame_done     = (state_r == ST_DONE);

`ifdef SCAN_ERR_CHECK_EN
    logic err_set_s;
    logic scan_err_r;

    // misuse detection: steps off the serpentine path or outside a scan
    always_comb begin
        err_set_s = 1'b0;
        case (state_r)
            ST_IDLE:  err_set_s = step_x || step_y;
            ST_RUN_R: err_set_s = (step_x && (step_y || x_max_s)) || (step_y && !x_max_s);
            ST_RUN_L: err_set_s = (step_x && (step_y || x_min_s)) || (step_y && !x_min_s);
            ST_DONE:  err_set_s = 1'b0;
            default:  err_set_s = 1'b0;
        endcase
    end

    // sticky error flag, cleared by abort or an accepted start
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scan_err_r <= 1'b0;
        end else if (clr_s) begin
            scan_err_r <= 1'b0;
        end else if (err_set_s) begin
            scan_err_r <= 1'b1;
        end else begin
            scan_err_r <= scan_err_r;
        end
    end

    assign scan_err = scan_err_r;
`endif

endmodule

// File: tb/tb_scan_controller.sv
// Directed bench for scan_controller at IMG_W=16, IMG_H=13, WIN=9 (X_MAX=7, Y_MAX=4).
module tb_scan_controller;

    logic       tb_clk = 1'b0;
    logic       n_rst;
    logic       start;
    logic       abort;
    logic       step_x;
    logic       step_y;
    logic [9:0]  readx;
    logic [9:0]  ready;
    logic [19:0] addr;
    logic       readx_up_max;
    logic       readx_down_min;
    logic       ready_max;
    logic       busy;
    logic       frame_done;
`ifdef SCAN_ERR_CHECK_EN
    logic       scan_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 tb_clk = ~tb_clk;

    scan_controller #(.IMG_W(16), .IMG_H(13), .WIN(9)) dut (
        .clk            (tb_clk),
        .n_rst          (n_rst),
        .start          (start),
        .abort          (abort),
        .step_x         (step_x),
        .step_y         (step_y),
        .readx          (readx),
        .ready          (ready),
        .addr           (addr),
        .readx_up_max   (readx_up_max),
        .readx_down_min (readx_down_min),
        .ready_max      (ready_max),
        .busy           (busy),
        .frame_done     (frame_done)
`ifdef SCAN_ERR_CHECK_EN
,       .scan_err       (scan_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // one clock with the given inputs held, then release them; sample 1 time unit after the edge
    task automatic pulse(input logic sx, input logic sy, input logic st, input logic ab);
        step_x = sx;
        step_y = sy;
        start  = st;
        abort  = ab;
        @(posedge tb_clk);
        #1;
        step_x = 1'b0;
        step_y = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_rst  = 1'b0;
        start  = 1'b0;
        abort  = 1'b0;
        step_x = 1'b0;
        step_y = 1'b0;
        #23;
        chk("rst_busy", busy, 0);
        chk("rst_readx", readx, 0);
        chk("rst_ready", ready, 0);
        chk("rst_addr", addr, 0);
        chk("rst_down_min", readx_down_min, 1);
        chk("rst_up_max", readx_up_max, 0);
        chk("rst_ready_max", ready_max, 0);
        chk("rst_frame_done", frame_done, 0);
        n_rst = 1'b1;
        @(posedge tb_clk);
        #1;

        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk("start_busy", busy, 1);
        chk("start_readx", readx, 0);
        chk("start_addr", addr, 0);
        chk("start_down_min", readx_down_min, 1);

        steps(7);
        chk("right7_readx", readx, 7);
        chk("right7_addr", addr, 7);
        chk("right7_up_max", readx_up_max, 1);
        steps(1);
        chk("right_hold_readx", readx, 7);
        chk("right_hold_addr", addr, 7);
`ifdef SCAN_ERR_CHECK_EN
        chk("err_right_bound", scan_err, 1);
`endif

        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("row1_ready", ready, 1);
        chk("row1_addr", addr, 23);
        chk("row1_readx", readx, 7);
        steps(7);
        chk("left7_readx", readx, 0);
        chk("left7_addr", addr, 16);
        chk("left7_down_min", readx_down_min, 1);

        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        chk("both_ready", ready, 2);
        chk("both_readx", readx, 0);
        chk("both_addr", addr, 32);
        steps(3);
        chk("dir_right_readx", readx, 3);
        chk("dir_right_addr", addr, 35);

        pulse(1'b1, 1'b1, 1'b1, 1'b1);
        chk("abort_busy", busy, 0);
        chk("abort_readx", readx, 0);
        chk("abort_ready", ready, 0);
        chk("abort_addr", addr, 0);
        chk("abort_frame_done", frame_done, 0);
`ifdef SCAN_ERR_CHECK_EN
        chk("err_abort_clr", scan_err, 0);
`endif
        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        chk("idle_ign_readx", readx, 0);
        chk("idle_ign_ready", ready, 0);
        chk("idle_ign_busy", busy, 0);
`ifdef SCAN_ERR_CHECK_EN
        chk("err_idle_step", scan_err, 1);
`endif
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk("restart_busy", busy, 1);
`ifdef SCAN_ERR_CHECK_EN
        chk("err_start_clr", scan_err, 0);
`endif

        // full serpentine; start mid-row must be ignored
        steps(3);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        chk("busy_start_readx", readx, 3);
        chk("busy_start_addr", addr, 3);
        for (int r = 0; r < 5; r++) begin
            steps((r == 0) ? 4 : 7);
            chk("row_end_readx", readx, (r % 2 == 0) ? 7 : 0);
            chk("row_end_addr", addr, r * 16 + ((r % 2 == 0) ? 7 : 0));
            if (r == 1) begin
`ifdef SCAN_ERR_CHECK_EN
                chk("err_clean_rows", scan_err, 0);
`endif
                steps(1);
                chk("left_hold_readx", readx, 0);
                chk("left_hold_addr", addr, 16);
`ifdef SCAN_ERR_CHECK_EN
                chk("err_left_bound", scan_err, 1);
`endif
            end
            if (r < 4) begin
                pulse(1'b0, 1'b1, 1'b0, 1'b0);
                chk("row_step_ready", ready, r + 1);
                chk("row_step_addr", addr, (r + 1) * 16 + ((r % 2 == 0) ? 7 : 0));
                chk("row_step_frame_done", frame_done, 0);
            end
        end
        chk("last_ready_max", ready_max, 1);
        chk("last_up_max", readx_up_max, 1);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        chk("done_pulse", frame_done, 1);
        chk("done_busy", busy, 1);
        pulse(1'b0, 1'b0, 1'b0, 1'b0);
        chk("done_end_pulse", frame_done, 0);
        chk("done_idle_busy", busy, 0);

        // asynchronous reset mid-scan
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        steps(2);
        chk("pre_arst_readx", readx, 2);
        #3;
        n_rst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_readx", readx, 0);
        chk("arst_addr", addr, 0);
        chk("arst_down_min", readx_down_min, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
